// File: rtl/key_conditioner_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    localparam int DEF_NUM_KEYS     = 4;
    localparam int DEF_DEBOUNCE     = 4;
    localparam int DEF_REPEAT_DELAY = 10;
    localparam int DEF_REPEAT_RATE  = 3;

    // One width serves every per-channel counter: wide enough for the largest terminal value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key pins in, conditioned levels and pulses out.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] repeat_en;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] step_pulse;

    modport master (
        output key_n, repeat_en,
        input  pressed, press_pulse, release_pulse, step_pulse
    );

    modport slave (
        input  key_n, repeat_en,
        output pressed, press_pulse, release_pulse, step_pulse
    );
endinterface

// File: rtl/key_conditioner_channel.sv
// One key: synchroniser, debounce, and auto-repeat state machine.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic repeat_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);

    logic          sync1, sync2;
    logic          raw_pressed, rise, fall;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] rp_cnt, rp_cnt_d;
    logic          tick, tick_d;
    rep_state_t    state, state_d;

    assign raw_pressed = ~sync2;
    // Level flips on the first disagreeing sample after the counter has reached its terminal value.
    assign rise = raw_pressed && !pressed && (db_cnt == CW'(DEBOUNCE_CYCLES));
    assign fall = !raw_pressed && pressed && (db_cnt == CW'(DEBOUNCE_CYCLES));
    assign step_pulse = press_pulse | tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            tick          <= 1'b0;
            rp_cnt        <= '0;
            state         <= IDLE;
        end else begin
            sync1         <= key_n;
            sync2         <= sync1;
            if (raw_pressed == pressed || rise || fall) db_cnt <= '0;
            else                                       db_cnt <= db_cnt + CW'(1);
            if (rise || fall) pressed <= ~pressed;
            press_pulse   <= rise;
            release_pulse <= fall;
            tick          <= tick_d;
            rp_cnt        <= rp_cnt_d;
            state         <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        rp_cnt_d = rp_cnt;
        tick_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_d  = DELAY;
                    rp_cnt_d = '0;
                end
            end
            DELAY: begin
                if (repeat_en) begin
                    if (rp_cnt == CW'(REPEAT_DELAY_CYCLES - 1)) begin
                        state_d  = REPEAT;
                        rp_cnt_d = '0;
                        tick_d   = 1'b1;
                    end else begin
                        rp_cnt_d = rp_cnt + CW'(1);
                    end
                end
            end
            REPEAT: begin
                if (repeat_en) begin
                    if (rp_cnt == CW'(REPEAT_RATE_CYCLES - 1)) begin
                        rp_cnt_d = '0;
                        tick_d   = 1'b1;
                    end else begin
                        rp_cnt_d = rp_cnt + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A release on the same edge as a due repeat swallows the repeat.
        if (fall) begin
            state_d  = IDLE;
            rp_cnt_d = '0;
            tick_d   = 1'b0;
        end
    end
endmodule

// File: rtl/key_conditioner.sv
// Array of independent key channels between the board pins and the clock controls.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS            = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE
) (
    input logic               clk,
    input logic               reset,
    key_conditioner_if.slave  bus
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .key_n         (bus.key_n[i]),
            .repeat_en     (bus.repeat_en[i]),
            .pressed       (bus.pressed[i]),
            .press_pulse   (bus.press_pulse[i]),
            .release_pulse (bus.release_pulse[i]),
            .step_pulse    (bus.step_pulse[i])
        );
    end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-side conditioner for the digital clock's push-buttons: takes the raw active-low board keys, synchronises and debounces each one, and emits single-cycle press, release and auto-repeat pulses. Sits between the board key pins and the control interface, so holding "minute up"/"hour up" steps the time at a steady rate. All logic runs on the design's divided system clock.

## Interface
Parameters:
- NUM_KEYS, 4, number of independent key channels
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a level change (≥1)
- REPEAT_DELAY_CYCLES, 10, held time after the press pulse before the first repeat (≥1)
- REPEAT_RATE_CYCLES, 3, interval between subsequent repeats (≥1)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- key_n  in  NUM_KEYS  raw board keys, active low, asynchronous to clk
- repeat_en  in  NUM_KEYS  per-key auto-repeat enable, sampled every cycle
- pressed  out  NUM_KEYS  debounced level, 1 = held
- press_pulse  out  NUM_KEYS  one-cycle pulse on accepted press
- release_pulse  out  NUM_KEYS  one-cycle pulse on accepted release
- step_pulse  out  NUM_KEYS  press pulse OR auto-repeat pulse; feed this to minute/hour-up inputs

## Operation
- Per channel: 2-flop synchroniser (flops reset to 1 = released), then raw_pressed = ~sync2.
- Debounce: counter counts consecutive cycles where raw_pressed ≠ pressed; any cycle with raw_pressed == pressed clears it. When it reaches DEBOUNCE_CYCLES, pressed toggles and the counter clears on that edge.
- press_pulse / release_pulse: high for exactly the cycle after pressed rises / falls.
- Repeat FSM per channel: IDLE → (pressed rises) DELAY → (counter hits REPEAT_DELAY_CYCLES) REPEAT → every REPEAT_RATE_CYCLES emit repeat. Any state → IDLE when pressed falls.
- Repeat counter counts only while repeat_en=1; dropping repeat_en holds the FSM in its state with the counter frozen, no repeats; raising it resumes.
- step_pulse = press_pulse | repeat tick. Press pulse is never suppressed by repeat_en.
- Counter widths: $clog2(max(param)+1); no wrap, counters saturate only by clearing at terminal count.
- Channels fully independent; simultaneous presses on several keys each pulse in the same cycle.

## Timing
- Reset values: pressed=0, all pulses 0, FSMs IDLE, counters 0, sync flops 1. Reset mid-operation clears immediately (async); a key still held after reset is re-accepted as a fresh press after normal latency.
- Press latency: key_n low steady from sampling edge k → press_pulse and step_pulse high in the cycle after edge k+2+DEBOUNCE_CYCLES (i.e. DEBOUNCE_CYCLES+2 clocks). Same for release.
- First repeat step_pulse: REPEAT_DELAY_CYCLES clocks after press_pulse; subsequent ones every REPEAT_RATE_CYCLES clocks.
- Bounce shorter than DEBOUNCE_CYCLES: no level change, no pulse.
- Release and a due repeat in the same cycle: release wins, no repeat pulse.
- Pulses are never wider than one cycle; pressed and a press_pulse assert together.

## Structure
- Package key_pkg: repeat-state enum (IDLE, DELAY, REPEAT), default parameter constants, counter-width helper function.
- Sub-module key_channel: synchroniser, debounce counter, repeat FSM for one key; key_conditioner is a generate loop of NUM_KEYS instances.

## Test plan
Defaults (D=4, DELAY=10, RATE=3), repeat_en=all 1 unless noted.
- Clean press of key0 held 40 cycles → press_pulse[0] and step_pulse[0] at edge D+2=6; step_pulse[0] again at 16, 19, 22, …; release gives release_pulse[0] 6 cycles after key_n rises, no further steps.
- Bounce: key_n[1] low 3 cycles, high 1, low 3 → no pulses, pressed[1] stays 0.
- repeat_en[2]=0 while held 30 cycles → exactly one step_pulse (the press); raise repeat_en → repeats resume from frozen count.
- Keys 0 and 3 pressed same cycle → identical, simultaneous pulse trains on both.
- Reset asserted mid-repeat with key held → all outputs 0 immediately; after deassert, press_pulse after 6 cycles.
- Release coinciding with repeat due cycle → release_pulse only, no step_pulse.
